// File: rtl/rf_writeback_scheduler_if.sv
// Writeback scheduler bus: issue port, two writeback requesters with
// valid/ready, read-hazard query and the register file write port.
//   master : issue/writeback/read-address side (drives requests)
//   slave  : the scheduler (drives Ready, Rd_Stall, Awr/Din/WrEn, Busy)
interface rf_writeback_scheduler_if #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
);
    logic                Iss_Valid;
    logic [ADDR_W-1:0]   Iss_Addr;
    logic                Req0_Valid;
    logic [ADDR_W-1:0]   Req0_Addr;
    logic [DATA_W-1:0]   Req0_Data;
    logic                Req0_Ready;
    logic                Req1_Valid;
    logic [ADDR_W-1:0]   Req1_Addr;
    logic [DATA_W-1:0]   Req1_Data;
    logic                Req1_Ready;
    logic [ADDR_W-1:0]   Rd_Adr1;
    logic [ADDR_W-1:0]   Rd_Adr2;
    logic                Rd_Stall;
    logic [ADDR_W-1:0]   Awr;
    logic [DATA_W-1:0]   Din;
    logic                WrEn;
    logic [NUM_REGS-1:0] Busy;

    modport master (
        output Iss_Valid, Iss_Addr,
        output Req0_Valid, Req0_Addr, Req0_Data,
        input  Req0_Ready,
        output Req1_Valid, Req1_Addr, Req1_Data,
        input  Req1_Ready,
        output Rd_Adr1, Rd_Adr2,
        input  Rd_Stall,
        input  Awr, Din, WrEn, Busy
    );

    modport slave (
        input  Iss_Valid, Iss_Addr,
        input  Req0_Valid, Req0_Addr, Req0_Data,
        output Req0_Ready,
        input  Req1_Valid, Req1_Addr, Req1_Data,
        output Req1_Ready,
        input  Rd_Adr1, Rd_Adr2,
        output Rd_Stall,
        output Awr, Din, WrEn, Busy
    );
endinterface

// File: rtl/rf_writeback_scheduler.sv
// Register file writeback scheduler.
// Shares the single RF write port between ALU writeback (Req0) and memory
// load writeback (Req1) with round-robin arbitration, drives a registered
// write port (Awr/Din/WrEn), and keeps a pending-write scoreboard (Busy)
// that produces the read-hazard stall.
//   Clk     : clock, rising edge
//   Reset_n : asynchronous active-low reset
//   wb      : scheduler side of rf_writeback_scheduler_if
module rf_writeback_scheduler #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    rf_writeback_scheduler_if.slave wb
);

    // 1 when Req1 won the last accepted transfer, so Req0 has priority next.
    // Reset value 1 gives Req0 priority on the first contention.
    logic              last_gnt1_q;
    logic              gnt0, gnt1, xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic [ADDR_W-1:0]   awr_q;
    logic [DATA_W-1:0]   din_q;
    logic                wren_q;
    logic [NUM_REGS-1:0] busy_q;

    // Grants are gated by Reset_n so no Ready is seen while held in reset.
    always_comb begin
        gnt0 = Reset_n && wb.Req0_Valid && (!wb.Req1_Valid ||  last_gnt1_q);
        gnt1 = Reset_n && wb.Req1_Valid && (!wb.Req0_Valid || !last_gnt1_q);
        xfer = gnt0 || gnt1;
        sel_addr = gnt1 ? wb.Req1_Addr : wb.Req0_Addr;
        sel_data = gnt1 ? wb.Req1_Data : wb.Req0_Data;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            last_gnt1_q <= 1'b1;
        else if (xfer)
            last_gnt1_q <= gnt1;
    end

    // Address and data hold when idle; only the enable pulses.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            awr_q  <= '0;
            din_q  <= '0;
            wren_q <= 1'b0;
        end else begin
            wren_q <= xfer && (sel_addr != '0);
            if (xfer) begin
                awr_q <= sel_addr;
                din_q <= sel_data;
            end
        end
    end

    // Scoreboard. A bit clears on the edge the RF captures the write
    // (WrEn high), so the value is readable the following cycle. A fresh
    // issue to the same register on that edge keeps the bit set.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_sb
        if (i == 0) begin : g_zero
            always_comb busy_q[i] = 1'b0;
        end else begin : g_reg
            logic set_hit, clr_hit;
            assign set_hit = wb.Iss_Valid && (wb.Iss_Addr == ADDR_W'(i));
            assign clr_hit = wren_q && (awr_q == ADDR_W'(i));
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n)
                    busy_q[i] <= 1'b0;
                else if (set_hit)
                    busy_q[i] <= 1'b1;
                else if (clr_hit)
                    busy_q[i] <= 1'b0;
            end
        end
    end

    assign wb.Req0_Ready = gnt0;
    assign wb.Req1_Ready = gnt1;
    assign wb.Awr        = awr_q;
    assign wb.Din        = din_q;
    assign wb.WrEn       = wren_q;
    assign wb.Busy       = busy_q;
    // busy_q[0] is constant 0, so address 0 never stalls.
    assign wb.Rd_Stall   = busy_q[wb.Rd_Adr1] || busy_q[wb.Rd_Adr2];

endmodule

// File: tb/tb_rf_writeback_scheduler.sv
// Directed, table-driven bench for rf_writeback_scheduler. Each row drives
// inputs for one cycle, checks the combinational outputs mid-cycle, then
// checks the registered outputs just after the following rising edge.
module tb_rf_writeback_scheduler;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    logic Clk;
    logic Reset_n;
    int   checks = 0;
    int   errors = 0;

    rf_writeback_scheduler_if #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rf_writeback_scheduler #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .wb      (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        iv;
        logic [4:0]  ia;
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [4:0]  rd1;
        logic [4:0]  rd2;
        logic        e_r0;
        logic        e_r1;
        logic        e_st;
        logic        e_we;
        logic [4:0]  e_awr;
        logic [31:0] e_din;
        logic [31:0] e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic iv, input logic [4:0] ia,
        input logic v0, input logic [4:0] a0, input logic [31:0] d0,
        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
        input logic [4:0] rd1, input logic [4:0] rd2,
        input logic e_r0, input logic e_r1, input logic e_st,
        input logic e_we, input logic [4:0] e_awr, input logic [31:0] e_din,
        input logic [31:0] e_busy);
        vec_t v;
        v.iv = iv; v.ia = ia; v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1; v.rd1 = rd1; v.rd2 = rd2;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_st = e_st; v.e_we = e_we;
        v.e_awr = e_awr; v.e_din = e_din; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.Iss_Valid  = 1'b0; bus.Iss_Addr  = '0;
        bus.Req0_Valid = 1'b0; bus.Req0_Addr = '0; bus.Req0_Data = '0;
        bus.Req1_Valid = 1'b0; bus.Req1_Addr = '0; bus.Req1_Data = '0;
        bus.Rd_Adr1    = '0;   bus.Rd_Adr2   = '0;
    endtask

    initial begin
        drive_idle();
        Reset_n = 1'b0;

        // ---- Rows: iv ia | v0 a0 d0 | v1 a1 d1 | rd1 rd2 || r0 r1 stall | wren awr din busy
        // Contention right after reset: Req0 first, then alternate.
        vecs.push_back(mk(0,0, 1,1,32'h11, 1,2,32'h22, 0,0, 1,0,0, 1,1,32'h11, 32'h0));
        vecs.push_back(mk(0,0, 1,3,32'h33, 1,2,32'h22, 0,0, 0,1,0, 1,2,32'h22, 32'h0));
        vecs.push_back(mk(0,0, 1,3,32'h33, 1,4,32'h44, 0,0, 1,0,0, 1,3,32'h33, 32'h0));
        vecs.push_back(mk(0,0, 1,5,32'h55, 1,4,32'h44, 0,0, 0,1,0, 1,4,32'h44, 32'h0));
        // Single Req0 write, then WrEn drops while Awr/Din hold.
        vecs.push_back(mk(0,0, 1,5,32'hDEADBEEF, 0,0,0, 0,0, 1,0,0, 1,5,32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,5,32'hDEADBEEF, 32'h0));
        // Issue 7, stall until Req1 writes 7; clears two cycles after the grant.
        vecs.push_back(mk(1,7, 0,0,0, 0,0,0, 7,0, 0,0,0, 0,5,32'hDEADBEEF, 32'h80));
        vecs.push_back(mk(0,0, 0,0,0, 0,0,0, 7,0, 0,0,1, 0,5,32'hDEADBEEF, 32'h80));
        vecs.push_back(mk(0,0, 0,0,0, 1,7,32'h77, 7,0, 0,1,1, 1,7,32'h77, 32'h80));
        vecs.push_back(mk(0,0, 0,0,0, 0,0,0, 7,0, 0,0,1, 0,7,32'h77, 32'h0));
        vecs.push_back(mk(0,0, 0,0,0, 0,0,0, 7,0, 0,0,0, 0,7,32'h77, 32'h0));
        // Issue 9, write 9, re-issue 9 on the clearing edge: bit stays set.
        vecs.push_back(mk(1,9, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,7,32'h77, 32'h200));
        vecs.push_back(mk(0,0, 1,9,32'h99, 0,0,0, 0,0, 1,0,0, 1,9,32'h99, 32'h200));
        vecs.push_back(mk(1,9, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,9,32'h99, 32'h200));
        // Issue to r0 is ignored; a write to r0 is granted but not enabled.
        vecs.push_back(mk(1,0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,9,32'h99, 32'h200));
        vecs.push_back(mk(0,0, 0,0,0, 1,0,32'hAA, 9,0, 0,1,1, 0,0,32'hAA, 32'h200));
        // Reads of r0/r3: no stall, then issue 3 stalls next cycle.
        vecs.push_back(mk(1,3, 0,0,0, 0,0,0, 0,3, 0,0,0, 0,0,32'hAA, 32'h208));
        vecs.push_back(mk(0,0, 0,0,0, 0,0,0, 0,3, 0,0,1, 0,0,32'hAA, 32'h208));

        // ---- Reset values
        #3;
        chk("rst_wren", {31'b0, bus.WrEn}, 32'h0);
        chk("rst_busy", bus.Busy, 32'h0);
        chk("rst_awr",  {27'b0, bus.Awr}, 32'h0);
        chk("rst_din",  bus.Din, 32'h0);
        repeat (2) @(posedge Clk);
        @(negedge Clk) Reset_n = 1'b1;

        // ---- Build WrEn=1, Busy=6, then reset mid-cycle
        @(negedge Clk);
        bus.Iss_Valid = 1'b1; bus.Iss_Addr = 5'd1;
        @(negedge Clk);
        bus.Iss_Addr   = 5'd2;
        bus.Req0_Valid = 1'b1; bus.Req0_Addr = 5'd5; bus.Req0_Data = 32'h1234;
        @(posedge Clk); #1;
        chk("pre_busy", bus.Busy, 32'h6);
        chk("pre_wren", {31'b0, bus.WrEn}, 32'h1);
        #1 Reset_n = 1'b0;
        #1;
        chk("midrst_wren",  {31'b0, bus.WrEn}, 32'h0);
        chk("midrst_busy",  bus.Busy, 32'h0);
        chk("midrst_awr",   {27'b0, bus.Awr}, 32'h0);
        chk("midrst_din",   bus.Din, 32'h0);
        chk("midrst_ready", {31'b0, bus.Req0_Ready}, 32'h0);
        drive_idle();
        @(negedge Clk) Reset_n = 1'b1;

        // ---- Table
        foreach (vecs[i]) begin
            @(negedge Clk);
            bus.Iss_Valid  = vecs[i].iv; bus.Iss_Addr  = vecs[i].ia;
            bus.Req0_Valid = vecs[i].v0; bus.Req0_Addr = vecs[i].a0; bus.Req0_Data = vecs[i].d0;
            bus.Req1_Valid = vecs[i].v1; bus.Req1_Addr = vecs[i].a1; bus.Req1_Data = vecs[i].d1;
            bus.Rd_Adr1    = vecs[i].rd1; bus.Rd_Adr2  = vecs[i].rd2;
            #1;
            chk($sformatf("row%0d_ready0", i), {31'b0, bus.Req0_Ready}, {31'b0, vecs[i].e_r0});
            chk($sformatf("row%0d_ready1", i), {31'b0, bus.Req1_Ready}, {31'b0, vecs[i].e_r1});
            chk($sformatf("row%0d_stall", i),  {31'b0, bus.Rd_Stall},   {31'b0, vecs[i].e_st});
            @(posedge Clk); #1;
            chk($sformatf("row%0d_wren", i), {31'b0, bus.WrEn}, {31'b0, vecs[i].e_we});
            chk($sformatf("row%0d_awr", i),  {27'b0, bus.Awr},  {27'b0, vecs[i].e_awr});
            chk($sformatf("row%0d_din", i),  bus.Din,  vecs[i].e_din);
            chk($sformatf("row%0d_busy", i), bus.Busy, vecs[i].e_busy);
        end

        @(negedge Clk) drive_idle();
        repeat (2) @(posedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
